// File: rtl/uart_receiver.sv
// uart_receiver: serial receive front end. Deserializes frames arriving on
// uart_rx (8N1, or 8E1 when UART_RX_PARITY_EN is defined) and buffers the
// received bytes in a small circular FIFO. The bytes are popped by the CPU
// I/O decode.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   uart_rx     serial line, idle high, asynchronous to clk
//   rd_en       pop the head byte (one-cycle pulse)
//   clr_status  clear the sticky overrun / frame_error flags
//   rx_data     FIFO head byte, 0 when the FIFO is empty
//   rx_valid    FIFO not empty
//   fifo_full   FIFO holds FIFO_DEPTH entries
//   overrun     sticky: a received byte was dropped because the FIFO was full
//   frame_error sticky: stop bit sampled low (or parity mismatch)
//   busy        receiver is inside a frame (START/DATA/PARITY/STOP)
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after bit 7).
module uart_receiver #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 174,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  input  logic                  rd_en,
  input  logic                  clr_status,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  fifo_full,
  output logic                  overrun,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  line;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  tick_half;
  logic                  tick_bit;
  logic                  push;
  logic                  stop_err;
  logic                  par_err;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           count;
  logic                  empty;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;
  logic                  drop;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      line    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      line    <= rx_meta;
    end
  end

  // Sample-point events decoded from the current state, so the FIFO write and
  // the flag updates land on the same edge as the corresponding sample.
  always_comb begin
    tick_half = (cnt == HALF_LAST);
    tick_bit  = (cnt == BIT_LAST);
    push      = (state == STOP) && tick_bit && line;
    stop_err  = (state == STOP) && tick_bit && !line;
    par_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err   = (state == PARITY) && tick_bit && (line != ^shreg);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WAIT_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        WAIT_IDLE: begin
          cnt <= '0;
          if (line) state <= IDLE;
        end
        IDLE: begin
          cnt <= '0;
          if (!line) begin
            state   <= START;
            busy    <= 1'b1;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tick_half) begin
            cnt <= '0;
            if (line) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_bit) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_bit) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_bit) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= line ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A push into a full FIFO still succeeds when a pop frees a slot on the
  // same edge.
  always_comb begin
    count   = wr_ptr - rd_ptr;
    empty   = (count == '0);
    full    = (count == DEPTH);
    do_pop  = rd_en && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
  end

  assign rx_valid  = !empty;
  assign fifo_full = full;
  assign rx_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // Sticky flags: a set event wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (drop)
        overrun <= 1'b1;
      else if (clr_status)
        overrun <= 1'b0;
      if (stop_err || par_err)
        frame_error <= 1'b1;
      else if (clr_status)
        frame_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit, 4-entry FIFO.
// The reference model is a byte queue plus two flags; frame timing is derived
// arithmetically from the bit period and the 2-cycle input synchronizer.
module tb_uart_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Posedges from the pin falling (just after edge P0) to the stop sample edge.
  localparam int STOP_EDGE = 2 + 1 + CPB / 2 + (NB - 1) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fifo_full;
  logic       overrun;
  logic       frame_error;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  logic [11:0] status;
  assign status = {rx_valid, fifo_full, overrun, frame_error, rx_data};

  uart_receiver #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rd_en      (rd_en),
    .clr_status (clr_status),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .fifo_full  (fifo_full),
    .overrun    (overrun),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_status();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    return {q.size() != 0, q.size() == DEPTH, m_ovr, m_fe, head};
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    if (!par_ok) m_fe = 1'b1;
    if (!stop_ok) m_fe = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
  endfunction

  function automatic void model_pop();
    if (q.size() != 0) void'(q.pop_front());
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endfunction

  // Starts at the next posedge (P0); returns just after edge P(NB*CPB), line
  // left at the stop bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [NB-1:0] bits;
    bits       = '0;
    bits[8:1]  = b;
`ifdef UART_RX_PARITY_EN
    bits[9]    = (^b) ^ par_flip;
`endif
    bits[NB-1] = stop_bit;
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      uart_rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge clk); #1;
    clr_status = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({status, busy} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {status, busy}, 13'h0);
    end
    model_reset();
    reset = 1'b0;
    idle(5);
    checks++;
    if ({status, busy} !== {exp_status(), 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", {status, busy}, {exp_status(), 1'b0});
    end
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL single_busy_pre: got %b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL single_busy_start: got %b expected 1", busy);
        end
        repeat (STOP_EDGE - 4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rx_valid, busy} !== 2'b01) begin
          errors++; $display("FAIL single_before_stop: valid/busy got %b expected 01", {rx_valid, busy});
        end
        @(negedge clk);
        checks++;
        if ({rx_valid, rx_data, busy} !== {1'b1, 8'hA5, 1'b0}) begin
          errors++;
          $display("FAIL single_after_stop: valid/data/busy got %h expected %h", {rx_valid, rx_data, busy}, {1'b1, 8'hA5, 1'b0});
        end
      end
    join
    model_frame(8'hA5, 1'b1, 1'b1);
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL single_status: got %h expected %h", status, exp_status());
    end
    pulse_rd();
    model_pop();
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL single_pop: got %h expected %h", status, exp_status());
    end
    pulse_rd();
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL pop_empty: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_glitch();
    int hi;
    int first;
    hi = 0;
    first = -1;
    idle(5);
    fork
      begin
        @(posedge clk); #1;
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (busy === 1'b1) begin
            hi++;
            if (first < 0) first = i;
          end
        end
      end
    join
    checks++;
    if (hi !== CPB / 2) begin
      errors++; $display("FAIL glitch_busy_len: got %0d expected %0d", hi, CPB / 2);
    end
    checks++;
    if (first !== 3) begin
      errors++; $display("FAIL glitch_busy_start: got %0d expected 3", first);
    end
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL glitch_status: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1);
      model_frame(8'(v), 1'b1, 1'b1);
      checks++;
      if (status !== exp_status()) begin
        errors++; $display("FAIL overflow_push%0d: got %h expected %h", v, status, exp_status());
      end
    end
    for (int k = 0; k < 4; k++) begin
      pulse_rd();
      model_pop();
      checks++;
      if (status !== exp_status()) begin
        errors++; $display("FAIL overflow_pop%0d: got %h expected %h", k, status, exp_status());
      end
    end
    pulse_clr();
    m_ovr = 1'b0;
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL overflow_clr: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_frame_error();
    int busyc;
    busyc = 0;
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) busyc++;
    end
    checks++;
    if (busyc !== 0) begin
      errors++; $display("FAIL ferr_wait_idle: busy cycles got %0d expected 0", busyc);
    end
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL ferr_status: got %h expected %h", status, exp_status());
    end
    @(posedge clk); #1;
    idle(3);
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1, 1'b1);
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL ferr_recover: got %h expected %h", status, exp_status());
    end
    pulse_rd();
    model_pop();
    pulse_clr();
    m_fe = 1'b0;
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL ferr_clr: got %h expected %h", status, exp_status());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    r = 8'($urandom_range(1, 255));
    send_frame(r, 1'b1);
    model_frame(r, 1'b1, 1'b1);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #1;
        checks++;
        if ({rx_valid, busy, rx_data} !== {2'b11, r}) begin
          errors++; $display("FAIL midreset_pre: got %h expected %h", {rx_valid, busy, rx_data}, {2'b11, r});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({status, busy} !== 13'h0) begin
          errors++; $display("FAIL midreset_async: got %h expected %h", {status, busy}, 13'h0);
        end
        repeat (NB * CPB - 5 * CPB - CPB / 2) @(posedge clk);
        #3;
        reset = 1'b0;
      end
    join
    model_reset();
    idle(3);
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b1, 1'b1);
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL midreset_next: got %h expected %h", status, exp_status());
    end
    pulse_rd();
    model_pop();
  endtask

  task automatic test_full_pop_push();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1, 1'b1);
    end
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL fpp_full: got %h expected %h", status, exp_status());
    end
    fork
      send_frame(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
      end
    join
    model_pop();
    q.push_back(8'h99);
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL fpp_same_cycle: got %h expected %h", status, exp_status());
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (status !== exp_status()) begin
        errors++; $display("FAIL fpp_drain%0d: got %h expected %h", k, status, exp_status());
      end
      pulse_rd();
      model_pop();
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    model_frame(8'h07, 1'b1, 1'b0);
    checks++;
    if (status !== exp_status()) begin
      errors++; $display("FAIL parity_error: got %h expected %h", status, exp_status());
    end
    pulse_rd();
    model_pop();
    pulse_clr();
    m_fe = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic       stop_ok;
    logic       par_ok;
    int         nrd;
    for (int f = 0; f < 16; f++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 4) == 0);
      par_ok   = !par_flip;
`endif
      send_frame(b, stop_ok);
`ifdef UART_RX_PARITY_EN
      par_flip = 1'b0;
`endif
      model_frame(b, stop_ok, par_ok);
      idle($urandom_range(2, 20));
      checks++;
      if (status !== exp_status()) begin
        errors++; $display("FAIL rand_frame%0d: got %h expected %h", f, status, exp_status());
      end
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        pulse_rd();
        model_pop();
        checks++;
        if (status !== exp_status()) begin
          errors++; $display("FAIL rand_pop%0d_%0d: got %h expected %h", f, k, status, exp_status());
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        checks++;
        if (status !== exp_status()) begin
          errors++; $display("FAIL rand_clr%0d: got %h expected %h", f, status, exp_status());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_overflow();
    test_frame_error();
    test_reset_midframe();
    test_full_pop_push();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive front end for the SAP-2 `computer`. It deserializes 8N1 frames arriving on `uart_rx` into bytes and buffers them in a small FIFO. The CPU's memory-mapped I/O decode pops bytes from the FIFO and reads status. It is the stage directly upstream of the CPU data bus on the receive path, and the bench drives its pin from the computer's `uart_tx` loopback.

## Interface
- `DATA_WIDTH`, 8: byte width; tied to `arch_defs_pkg::DATA_WIDTH`.
- `CLKS_PER_BIT`, 174: clock cycles per bit; must be ≥ 8.
- `FIFO_DEPTH`, 4: receive buffer entries; power of two, ≥ 2.
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high.
- `uart_rx` in 1: serial line; idle high; asynchronous to `clk`.
- `rd_en` in 1: pop head byte; one-cycle pulse from I/O decode.
- `clr_status` in 1: clear sticky error flags.
- `rx_data` out DATA_WIDTH: FIFO head byte; reads 0 when empty.
- `rx_valid` out 1: FIFO not empty.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH entries.
- `overrun` out 1: sticky; a received byte was dropped because the FIFO was full.
- `frame_error` out 1: sticky; stop bit sampled low (or parity mismatch when enabled).
- `busy` out 1: FSM is in START, DATA, PARITY or STOP.

## Operation
- Input sync: 2-FF synchronizer on `uart_rx`, both flops reset to 1. "Line" below means the synchronizer output.
- FSM states: WAIT_IDLE, IDLE, START, DATA, [PARITY], STOP.
  - WAIT_IDLE: entered on reset and after a frame error. Goes to IDLE on the first cycle the line is 1.
  - IDLE: line 0 → START, bit counter cleared.
  - START: waits CLKS_PER_BIT/2 cycles (integer divide), then samples the line.
    - 1 → IDLE; false start, nothing recorded.
    - 0 → DATA.
  - DATA: samples every CLKS_PER_BIT cycles and shifts LSB first. After the 8th sample → PARITY if enabled, else STOP.
  - STOP: samples after CLKS_PER_BIT cycles.
    - 1 → push byte, go to IDLE.
    - 0 → set frame_error, discard byte, go to WAIT_IDLE.
- FIFO: circular, read/write pointers one bit wider than the address.
  - Push while full and no pop in the same cycle: byte dropped, overrun set, pointers unchanged.
  - Push and pop in the same cycle while full: both take effect; count unchanged; no overrun.
  - `rd_en` while empty: ignored.
- Sticky flags:
  - Set has priority over `clr_status` in the same cycle.
  - Flags never clear on their own.
  - Flags do not block reception.

## Timing
- Reset, at any time including mid-frame:
  - State → WAIT_IDLE; FIFO pointers → 0.
  - `rx_valid`, `fifo_full`, `overrun`, `frame_error`, `busy` → 0; `rx_data` → 0.
- Let T0 be the first cycle the line is 0 in IDLE; this is 2 cycles after the pin falls.
- START sample at T0 + CLKS_PER_BIT/2.
- Data bit k (0..7) sample at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Stop sample at T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT, or +10 with parity.
- The push register is updated on the stop-sample edge. `rx_valid` and `rx_data` are valid the following cycle.
- `rd_en` at edge N: the next entry (or 0 when empty) appears on `rx_data` after edge N. `rx_valid` deasserts after edge N if the FIFO became empty.
- The FSM returns to IDLE in the stop-sample cycle, so a start bit immediately following the stop bit is accepted. Line sensitivity begins the next cycle.
- `busy` is registered and follows the state with no added latency.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1; PARITY state samples one extra bit CLKS_PER_BIT after bit 7.
  - A mismatch with even parity over the data bits sets frame_error.
  - The byte is still checked for stop and, if the stop bit is good, pushed.
- Undefined: frames are 8N1, the PARITY state and its logic are absent, and frame_error reflects stop-bit errors only.

## Test plan
- Bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Send 0xA5 at 16 clk/bit → `rx_valid`=1, `rx_data`=0xA5 exactly 1 cycle after the stop sample; `rd_en` → `rx_valid`=0, `rx_data`=0x00.
- 4-cycle low glitch on idle line → FSM returns to IDLE at the START sample; no push; no flags; `busy` high only during START.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 without reads → `fifo_full`=1 after 0x04; `overrun`=1 after 0x05; pops return 0x01..0x04 in order; `clr_status` → `overrun`=0.
- Frame 0x3C with stop bit forced low → `frame_error`=1, nothing pushed. Line held low 40 cycles → FSM stays in WAIT_IDLE. Line released, then 0x7E sent → 0x7E received.
- Assert `reset` at data bit 4 of 0x55 → all outputs 0 asynchronously; a following 0xC3 frame is received intact.
- FIFO full and `rd_en` in the same cycle as a push of 0x99 → `overrun` stays 0, `fifo_full` stays 1, 0x99 is the last entry popped. With `UART_RX_PARITY_EN`: 0x07 sent with parity bit 0 → `frame_error`=1 and 0x07 pushed.
